// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer, flush, store-data alignment
// and a saturating memory-side stall counter. ex_ready is registered.
module ex_mem_skid_reg #(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned REG_BITS     = 5,
  parameter int unsigned CNT_WIDTH    = 16,
  localparam int unsigned BE_W        = DATA_WIDTH / 8,
  localparam int unsigned OFF_W       = $clog2(BE_W)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,

  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic                    ex_memRead,
  input  logic                    ex_memWrite,
  input  logic                    ex_regWrite,
  input  logic [1:0]              ex_size,
  input  logic [DATA_WIDTH-1:0]   ex_ALU_result,
  input  logic [DATA_WIDTH-1:0]   ex_rs2_data,
  input  logic [REG_BITS-1:0]     ex_rd,

  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_load,
  output logic                    mem_store,
  output logic                    mem_regWrite,
  output logic [DATA_WIDTH-1:0]   mem_ALU_result,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_store_data,
  output logic [BE_W-1:0]         mem_byte_en,
  output logic                    mem_misaligned,
  output logic [REG_BITS-1:0]     mem_rd,
  output logic [CNT_WIDTH-1:0]    stall_count
);

  localparam bit NoDouble = (DATA_WIDTH == 32);

  typedef struct packed {
    logic                  load;
    logic                  store;
    logic                  regw;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] sdata;
    logic [BE_W-1:0]       be;
    logic                  mis;
    logic [REG_BITS-1:0]   rd;
  } entry_t;

  logic unused_core;
  assign unused_core = ^CORE;

  // ---------------------------------------------------------------------------
  // Capture-time alignment of the incoming EX entry
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]  off;
  logic [3:0]        nbytes;
  logic [OFF_W-1:0]  align_mask;
  logic [7:0]        lane_mask;
  logic [BE_W+7:0]   be_shift;
  logic              cap_mis;
  entry_t            cap;

  always_comb begin
    off        = ex_ALU_result[OFF_W-1:0];
    nbytes     = 4'd1 << ex_size;
    align_mask = OFF_W'(nbytes - 4'd1);
    unique case (ex_size)
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
    be_shift = (BE_W + 8)'(lane_mask) << off;
    // Double-word accesses do not exist on a 32-bit datapath.
    cap_mis  = (|(off & align_mask)) | ((ex_size == 2'b11) & NoDouble);

    cap       = '0;
    cap.load  = ex_memRead;
    cap.store = ex_memWrite;
    cap.regw  = ex_regWrite;
    cap.alu   = ex_ALU_result;
    cap.sdata = ex_rs2_data << {off, 3'b000};
    cap.be    = ((ex_memRead | ex_memWrite) & ~cap_mis) ? be_shift[BE_W-1:0] : '0;
    cap.mis   = cap_mis;
    cap.rd    = ex_rd;
  end

  // ---------------------------------------------------------------------------
  // Output / skid storage and flow control
  // ---------------------------------------------------------------------------
  entry_t               out_q, out_d;
  entry_t               skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 ready_q, ready_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic accept;
  logic consume;

  assign accept  = ex_valid & ready_q;
  assign consume = out_valid_q & mem_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      out_d        = '0;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({out_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            out_d       = cap;
            out_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (consume && accept) begin
            out_d = cap;
          end else if (consume) begin
            // Clearing the entry keeps control outputs low while empty.
            out_d       = '0;
            out_valid_d = 1'b0;
          end else if (accept) begin
            skid_d       = cap;
            skid_valid_d = 1'b1;
          end
        end
        2'b11: begin
          if (consume) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          out_d        = '0;
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    ready_d = ~(out_valid_d & skid_valid_d);
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !mem_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      stall_q      <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      stall_q      <= stall_d;
    end
  end

  assign ex_ready       = ready_q;
  assign mem_valid      = out_valid_q;
  assign mem_load       = out_q.load;
  assign mem_store      = out_q.store;
  assign mem_regWrite   = out_q.regw;
  assign mem_ALU_result = out_q.alu;
  assign mem_address    = out_q.alu[ADDRESS_BITS-1:0];
  assign mem_store_data = out_q.sdata;
  assign mem_byte_en    = out_q.be;
  assign mem_misaligned = out_q.mis;
  assign mem_rd         = out_q.rd;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: directed scenarios followed by random traffic,
// with a queue-based occupancy model and arithmetic alignment reference.
module tb_ex_mem_skid_reg;
  localparam int DW = 32;
  localparam int AB = 20;
  localparam int RB = 5;
  localparam int CW = 4;
  localparam int CntMax = 15;

  logic          clock = 1'b0;
  logic          reset, flush;
  logic          ex_valid, ex_ready, ex_memRead, ex_memWrite, ex_regWrite;
  logic [1:0]    ex_size;
  logic [DW-1:0] ex_ALU_result, ex_rs2_data;
  logic [RB-1:0] ex_rd;
  logic          mem_valid, mem_ready, mem_load, mem_store, mem_regWrite;
  logic [DW-1:0] mem_ALU_result, mem_store_data;
  logic [AB-1:0] mem_address;
  logic [3:0]    mem_byte_en;
  logic          mem_misaligned;
  logic [RB-1:0] mem_rd;
  logic [CW-1:0] stall_count;

  always #5 clock = ~clock;

  ex_mem_skid_reg #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .REG_BITS(RB), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite), .ex_size(ex_size),
    .ex_ALU_result(ex_ALU_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_load(mem_load),
    .mem_store(mem_store), .mem_regWrite(mem_regWrite), .mem_ALU_result(mem_ALU_result),
    .mem_address(mem_address), .mem_store_data(mem_store_data), .mem_byte_en(mem_byte_en),
    .mem_misaligned(mem_misaligned), .mem_rd(mem_rd), .stall_count(stall_count)
  );

  typedef struct {
    bit          load, store, regw;
    bit [31:0]   alu;
    bit [19:0]   addr;
    bit [31:0]   sd;
    bit [3:0]    be;
    bit          mis;
    bit [4:0]    rd;
  } exp_t;

  exp_t q[$];
  exp_t pend_item;
  bit   pend = 0;
  int   checks = 0;
  int   errors = 0;
  int   stall_exp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(bit mr, bit mw, bit rw, bit [1:0] sz, bit [31:0] alu,
                                 bit [31:0] rs2, bit [4:0] rd);
    exp_t e;
    int off = int'(alu % 4);
    int nb  = 1 << sz;
    longint unsigned w = 64'(rs2);
    e.load  = mr;
    e.store = mw;
    e.regw  = rw;
    e.alu   = alu;
    e.addr  = alu[19:0];
    e.rd    = rd;
    e.mis   = ((off % nb) != 0) || (sz == 2'b11);
    w       = (w << (8 * off)) & 64'hFFFF_FFFF;
    e.sd    = w[31:0];
    e.be    = ((mr || mw) && !e.mis) ? 4'((((1 << nb) - 1) << off) & 15) : 4'h0;
    return e;
  endfunction

  // Inputs change 1 time unit after the rising edge; acceptance is judged at the falling edge.
  task automatic drive(input bit rst, input bit fl, input bit v, input bit mr, input bit mw,
                       input bit rw, input bit [1:0] sz, input bit [31:0] alu,
                       input bit [31:0] rs2, input bit [4:0] rd, input bit rdy,
                       output bit acc);
    @(posedge clock);
    #1;
    reset = rst; flush = fl; ex_valid = v; ex_memRead = mr; ex_memWrite = mw;
    ex_regWrite = rw; ex_size = sz; ex_ALU_result = alu; ex_rs2_data = rs2; ex_rd = rd;
    mem_ready = rdy;
    @(negedge clock);
    acc = v && (ex_ready === 1'b1) && !fl && !rst;
    if (acc) begin
      pend_item = model(mr, mw, rw, sz, alu, rs2, rd);
      pend      = 1;
    end
  endtask

  task automatic idle(input bit rdy);
    bit a;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, rdy, a);
  endtask

  task automatic do_reset(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 1, a);
  endtask

  task automatic offer(input bit mr, input bit mw, input bit rw, input bit [1:0] sz,
                       input bit [31:0] alu, input bit [31:0] rs2, input bit [4:0] rd,
                       input bit rdy, output bit acc);
    drive(0, 0, 1, mr, mw, rw, sz, alu, rs2, rd, rdy, acc);
  endtask

  // Accepted entries join the expected queue at the edge that captures them.
  initial begin
    forever begin
      @(posedge clock);
      if (pend) begin
        q.push_back(pend_item);
        pend = 0;
      end
    end
  end

  // Monitor: queue length is the model occupancy.
  initial begin
    bit   started = 0;
    bit   rst_last = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!started) begin
        if (reset === 1'b1) begin
          started = 1; rst_last = 1; q.delete(); stall_exp = 0;
        end
        continue;
      end
      if (rst_last) begin
        chk("rst_outputs", {mem_load, mem_store, mem_regWrite, mem_misaligned, mem_byte_en,
                            mem_rd}, 64'h0);
        chk("rst_data", {mem_ALU_result, mem_store_data}, 64'h0);
        chk("rst_address", 64'(mem_address), 64'h0);
      end
      chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
      chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
      chk("stall_count", 64'(stall_count), 64'(stall_exp));
      if (mem_valid !== 1'b1) chk("idle_ctrl", {mem_load, mem_store, mem_regWrite}, 64'h0);
      if (reset) begin
        q.delete(); stall_exp = 0; rst_last = 1;
        continue;
      end
      rst_last = 0;
      if (q.size() != 0 && !mem_ready && stall_exp < CntMax) stall_exp++;
      if (mem_valid === 1'b1 && mem_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: alu %0h with empty scoreboard", mem_ALU_result);
        end else begin
          e = q.pop_front();
          chk("out_ctrl", {mem_load, mem_store, mem_regWrite}, {e.load, e.store, e.regw});
          chk("out_alu", 64'(mem_ALU_result), 64'(e.alu));
          chk("out_addr", 64'(mem_address), 64'(e.addr));
          chk("out_sdata", 64'(mem_store_data), 64'(e.sd));
          chk("out_be", 64'(mem_byte_en), 64'(e.be));
          chk("out_mis", 64'(mem_misaligned), 64'(e.mis));
          chk("out_rd", 64'(mem_rd), 64'(e.rd));
        end
      end
      if (flush) q.delete();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit got;
    reset = 1; flush = 0; ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_regWrite = 0;
    ex_size = 0; ex_ALU_result = 0; ex_rs2_data = 0; ex_rd = 0; mem_ready = 1;
    do_reset(3);
    idle(1);
    chk("reset_ready", 64'(ex_ready), 64'h1);
    chk("reset_valid", 64'(mem_valid), 64'h0);

    // Half-word load at offset 2
    offer(1, 0, 1, 2'b01, 32'h0000_1002, 32'h0, 5'd3, 1, acc);
    chk("load_not_early", 64'(mem_valid), 64'h0);
    idle(1);
    chk("load_valid", 64'(mem_valid), 64'h1);
    chk("load_be", 64'(mem_byte_en), 64'hC);
    chk("load_mis", 64'(mem_misaligned), 64'h0);
    chk("load_flag", 64'(mem_load), 64'h1);

    offer(0, 1, 0, 2'b10, 32'h0000_2000, 32'hAABB_CCDD, 5'd0, 1, acc);
    idle(1);
    chk("sw_data", 64'(mem_store_data), 64'hAABB_CCDD);
    chk("sw_be", 64'(mem_byte_en), 64'hF);
    offer(0, 1, 0, 2'b00, 32'h0000_2003, 32'hAABB_CCDD, 5'd0, 1, acc);
    idle(1);
    chk("sb_data", 64'(mem_store_data), 64'hDD00_0000);
    chk("sb_be", 64'(mem_byte_en), 64'h8);
    offer(0, 1, 0, 2'b01, 32'h0000_2001, 32'hAABB_CCDD, 5'd0, 1, acc);
    idle(1);
    chk("sh_mis", 64'(mem_misaligned), 64'h1);
    chk("sh_be", 64'(mem_byte_en), 64'h0);

    // A,B,C stream with a 3-cycle memory stall starting when A is presented
    do_reset(1);
    offer(1, 0, 1, 2'b10, 32'h0000_00A0, 32'h0, 5'd1, 1, acc);
    offer(1, 0, 1, 2'b10, 32'h0000_00B0, 32'h0, 5'd2, 0, acc);
    chk("b_accepted", 64'(acc), 64'h1);
    offer(1, 0, 1, 2'b10, 32'h0000_00C0, 32'h0, 5'd3, 0, acc);
    chk("full_ready_low", 64'(ex_ready), 64'h0);
    offer(1, 0, 1, 2'b10, 32'h0000_00C0, 32'h0, 5'd3, 0, acc);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      offer(1, 0, 1, 2'b10, 32'h0000_00C0, 32'h0, 5'd3, 1, acc);
      got = acc;
    end
    chk("c_accepted", 64'(got), 64'h1);
    repeat (3) idle(1);
    chk("abc_stall", 64'(stall_count), 64'h3);
    chk("abc_drained", 64'(q.size()), 64'h0);

    // Flush with both entries held and a new input offered
    do_reset(1);
    offer(1, 0, 1, 2'b10, 32'h0000_0100, 32'h0, 5'd4, 0, acc);
    offer(1, 0, 1, 2'b10, 32'h0000_0104, 32'h0, 5'd5, 0, acc);
    drive(0, 1, 1, 0, 1, 0, 2'b10, 32'h0000_0DD0, 32'h1234_5678, 5'd6, 0, acc);
    idle(1);
    chk("flush_valid", 64'(mem_valid), 64'h0);
    chk("flush_ready", 64'(ex_ready), 64'h1);
    repeat (3) idle(1);
    chk("flush_dropped", 64'(mem_valid), 64'h0);

    // Counter saturation, then reset mid-stall
    do_reset(1);
    offer(0, 1, 0, 2'b10, 32'h0000_0200, 32'h5555_AAAA, 5'd7, 0, acc);
    repeat (20) idle(0);
    chk("stall_sat", 64'(stall_count), 64'hF);
    do_reset(1);
    idle(0);
    chk("rst2_valid", 64'(mem_valid), 64'h0);
    chk("rst2_ready", 64'(ex_ready), 64'h1);
    chk("rst2_stall", 64'(stall_count), 64'h0);
    chk("rst2_be", 64'(mem_byte_en), 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
      end else begin
        drive(0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
              $urandom_range(0, 2) != 0, acc);
      end
    end
    repeat (4) idle(1);
    chk("final_drained", 64'(q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised Execute/Memory pipeline register with valid/ready flow control, a two-entry skid buffer, flush, store-data alignment and a stall counter. It sits between the EX stage and the data-memory stage. The memory side can stall for any number of cycles without a combinational ready path back into EX, and a flush discards in-flight work. Store data and byte enables are produced already aligned to the address offset.

## Interface
- CORE, 0, core index, informational only
- DATA_WIDTH, 32, datapath width; legal values 32 or 64
- ADDRESS_BITS, 20, width of the memory address output
- REG_BITS, 5, register-index width
- CNT_WIDTH, 16, stall-counter width
- BE_W is derived as DATA_WIDTH/8; OFF_W is derived as log2(BE_W)

- clock  in  1  rising-edge clock; the block has one clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  block can accept; registered
- ex_memRead, ex_memWrite, ex_regWrite  in  1 each  control bits
- ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (64-bit only)
- ex_ALU_result  in  DATA_WIDTH  address / result
- ex_rs2_data  in  DATA_WIDTH  raw store data
- ex_rd  in  REG_BITS  destination register
- mem_valid  out  1  output entry valid
- mem_ready  in  1  memory stage consumes the entry
- mem_load, mem_store, mem_regWrite  out  1 each  control bits, 0 whenever mem_valid=0
- mem_ALU_result  out  DATA_WIDTH  registered ALU result
- mem_address  out  ADDRESS_BITS  mem_ALU_result[ADDRESS_BITS-1:0]
- mem_store_data  out  DATA_WIDTH  aligned store data
- mem_byte_en  out  BE_W  byte enables, 0 unless a legal store or load
- mem_misaligned  out  1  access not size-aligned
- mem_rd  out  REG_BITS  destination register
- stall_count  out  CNT_WIDTH  saturating count of memory-side stall cycles

## Operation
- Storage: one output register (OUT) and one skid register (SKID). Occupancy is 0, 1 or 2.
- Handshakes:
  - Input accept = ex_valid & ex_ready.
  - Output consume = mem_valid & mem_ready.
- ex_ready = (occupancy != 2), held in a register.
- Transitions per cycle; flush=0 is required for all of them:
  - occ0 + accept: OUT<=in, go to occ1.
  - occ1, consume + accept: OUT<=in, stay in occ1.
  - occ1, consume only: go to occ0.
  - occ1, accept only: SKID<=in, go to occ2.
  - occ2, consume: OUT<=SKID, go to occ1. ex_ready=0, so no accept is possible.
  - No handshake: state holds.
- Flush has priority over everything. Occupancy goes to 0, mem_valid=0, and ex_ready=1 on the next cycle. An input offered in the flush cycle is dropped, and a consume in the same cycle is still treated as done by the memory stage.
- Alignment is computed at capture time, before the entry is stored:
  - off = ex_ALU_result[OFF_W-1:0]
  - nbytes = 1<<ex_size
  - misaligned = (off mod nbytes) != 0, or ex_size=11 when DATA_WIDTH=32
  - store_data = ex_rs2_data << (8*off), truncated to DATA_WIDTH
  - byte_en = ((1<<nbytes)-1) << off, truncated to BE_W, when (memRead|memWrite) & ~misaligned; otherwise 0
- A misaligned entry keeps memRead/memWrite as captured. The memory stage traps on mem_misaligned.
- stall_count increments each cycle where mem_valid & ~mem_ready. It saturates at all-ones and clears only on reset.

## Timing
- Reset values:
  - ex_ready=1
  - stall_count=0
  - mem_valid=0
  - every other output =0
  - occupancy=0
- Latency: an accept in cycle N gives mem_valid=1 in cycle N+1 when occupancy was 0 or the output was consumed in N.
- Throughput: one entry per cycle while mem_ready=1.
- Full: the second accept while OUT is stalled fills SKID, and ex_ready falls in the following cycle. ex_ready returns to 1 the cycle after the first consume.
- No input-to-output combinational paths. All outputs are registered, except mem_address, which is a bit-select of a register.
- Reset mid-operation: both entries are lost and the counter clears. Reset has priority over flush.

## Test plan
- Single load, off=2, size=01, addr 0x0000_1002, mem_ready=1:
  - mem_valid is high exactly 1 cycle later.
  - mem_byte_en=4'b1100, mem_misaligned=0, mem_load=1.
- Store word of data 0xAABBCCDD at off=0:
  - mem_store_data=0xAABBCCDD, byte_en=4'b1111.
- Same store as a byte store at off=3:
  - store_data=0xDD000000, byte_en=4'b1000.
- Half store at off=1:
  - mem_misaligned=1, byte_en=0.
- Back-to-back stream A,B,C with mem_ready low for 3 cycles starting when A is output:
  - B goes to SKID and ex_ready drops.
  - C is held upstream.
  - Output order is A,B,C with no loss or duplication.
  - stall_count=3.
- Flush while occ2 with ex_valid high:
  - mem_valid=0 and ex_ready=1 next cycle.
  - The input offered in the flush cycle never appears at the output.
- stall_count saturation with CNT_WIDTH=4: hold a stall for 20 cycles -> stall_count=15. Then assert reset -> all outputs at reset values, ex_ready=1.
